char_glyph_reader: RTL

Read-side client of the character glyph memory array. Given a character index, it sweeps all 16 pixel addresses of the array and picks that character's bit from the 36-bit parallel output on each cycle. It assembles the bits into a 16-bit glyph word and hands the word to the VGA text renderer over a valid/ready handshake. It never writes the array.

---
 rtl/char_glyph_pkg.sv | 27 ++
 rtl/glyph_capture_pipe.sv | 51 +++++
 rtl/char_glyph_reader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/char_glyph_pkg.sv
// Shared constants, FSM state type and pixel-address split helpers for the
// character glyph reader.
package char_glyph_pkg;

  localparam int NUM_CHARS  = 36;
  localparam int GLYPH_BITS = 16;
  localparam int CHAR_IDX_W = 6;
  localparam int ADDR_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_e;

  // Pixel column for glyph bit k.
  function automatic logic [1:0] addr_x(input logic [ADDR_W-1:0] k);
    return k[1:0];
  endfunction

  // Pixel row for glyph bit k; the array's upper row bit is never used.
  function automatic logic [2:0] addr_y(input logic [ADDR_W-1:0] k);
    return {1'b0, k[3:2]};
  endfunction

endpackage

// File: rtl/glyph_capture_pipe.sv
// Delay line that carries {valid, bit index} alongside the memory read
// latency, so each returning data word is written to the right glyph bit.
module glyph_capture_pipe #(
  parameter int LATENCY = 1,
  parameter int IDX_W   = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  if (LATENCY == 0) begin : g_bypass
    assign out_valid = in_valid;
    assign out_idx   = in_idx;
  end else begin : g_delay
    logic [LATENCY-1:0] valid_d, valid_q;
    logic [IDX_W-1:0]   idx_d [LATENCY];
    logic [IDX_W-1:0]   idx_q [LATENCY];

    // Shift every stage one step toward the output.
    always_comb begin
      valid_d = '0;
      for (int s = 0; s < LATENCY; s++) idx_d[s] = '0;
      valid_d[0] = in_valid;
      idx_d[0]   = in_idx;
      for (int s = 1; s < LATENCY; s++) begin
        valid_d[s] = valid_q[s-1];
        idx_d[s]   = idx_q[s-1];
      end
    end

    // Valid bits are reset so an aborted fetch leaves nothing in flight.
    always_ff @(posedge clock or posedge rst) begin
      if (rst) valid_q <= '0;
      else     valid_q <= valid_d;
    end

    // NOTE: index stages carry no reset; they are only looked at when the
    // matching valid bit is set.
    always_ff @(posedge clock) begin
      for (int s = 0; s < LATENCY; s++) idx_q[s] <= idx_d[s];
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_idx   = idx_q[LATENCY-1];
  end

endmodule

// File: rtl/char_glyph_reader.sv
// Read-side client of the glyph memory: sweeps the 16 pixel addresses,
// picks the requested character's bit from the parallel output, and hands
// the assembled glyph to the renderer over a valid/ready handshake.
module char_glyph_reader #(
  parameter int NUM_CHARS   = 36,
  parameter int MEM_LATENCY = 1
) (
  input  logic                                 clock,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [char_glyph_pkg::CHAR_IDX_W-1:0] req_char,
  output logic                                 glyph_valid,
  input  logic                                 glyph_ready,
  output logic [char_glyph_pkg::GLYPH_BITS-1:0] glyph_data,
  output logic                                 glyph_err,
  output logic                                 mem_write,
  output logic [1:0]                           mem_x,
  output logic [2:0]                           mem_y,
  input  logic [NUM_CHARS-1:0]                 mem_data_out
);

  import char_glyph_pkg::*;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_cnt_q, addr_cnt_d;
  logic [CHAR_IDX_W-1:0]   char_q, char_d;
  logic [GLYPH_BITS-1:0]   glyph_q, glyph_d;
  logic                    err_q, err_d;
  logic                    valid_q, valid_d;
  logic                    ready_q, ready_d;
  logic [1:0]              mem_x_q, mem_x_d;
  logic [2:0]              mem_y_q, mem_y_d;

  logic                    scan_active;
  logic                    pipe_valid;
  logic [ADDR_W-1:0]       pipe_idx;
  logic                    last_capture;

  assign scan_active  = (state_q == SCAN);
  assign last_capture = pipe_valid && (pipe_idx == 4'd15);

  glyph_capture_pipe #(
    .LATENCY (MEM_LATENCY),
    .IDX_W   (ADDR_W)
  ) u_capture_pipe (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (scan_active),
    .in_idx    (addr_cnt_q),
    .out_valid (pipe_valid),
    .out_idx   (pipe_idx)
  );

  // Next-state, address sweep and glyph assembly.
  // NOTE: every _d gets its hold value first, so no path through the case
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    char_d     = char_q;
    glyph_d    = glyph_q;
    err_d      = err_q;
    valid_d    = valid_q;
    ready_d    = ready_q;

    if (pipe_valid) glyph_d[pipe_idx] = mem_data_out[char_q];

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          char_d     = req_char;
          glyph_d    = '0;
          ready_d    = 1'b0;
          addr_cnt_d = '0;
          if (int'(req_char) < NUM_CHARS) begin
            state_d = SCAN;
            err_d   = 1'b0;
          end else begin
            // No memory access; the error glyph is presented a cycle later.
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      SCAN: begin
        addr_cnt_d = addr_cnt_q + 4'd1;
        if (addr_cnt_q == 4'd15) begin
          if (MEM_LATENCY == 0) begin
            state_d = DONE;
            valid_d = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_capture) begin
          state_d = DONE;
          valid_d = 1'b1;
        end
      end
      DONE: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (glyph_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered address outputs follow the next counter value while scanning.
    mem_x_d = (state_d == SCAN) ? addr_x(addr_cnt_d) : 2'd0;
    mem_y_d = (state_d == SCAN) ? addr_y(addr_cnt_d) : 3'd0;
  end

  // State and output registers; reset aborts any fetch in progress.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_cnt_q <= '0;
      char_q     <= '0;
      glyph_q    <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      mem_x_q    <= '0;
      mem_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      char_q     <= char_d;
      glyph_q    <= glyph_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      mem_x_q    <= mem_x_d;
      mem_y_q    <= mem_y_d;
    end
  end

  assign req_ready   = ready_q;
  assign glyph_valid = valid_q;
  assign glyph_data  = glyph_q;
  assign glyph_err   = err_q;
  assign mem_write   = 1'b0;
  assign mem_x       = mem_x_q;
  assign mem_y       = mem_y_q;

endmodule
